// File: rtl/metronome_arm_sequencer.sv
// Ping-pong arm position sequencer for the metronome arm ROM: steps the arm at a
// programmable rate, pulses beat at each sweep end, and latches the ROM address once per frame.
module metronome_arm_sequencer #(
    parameter int ADDR_WIDTH   = 7,
    parameter int POS_MAX      = 127,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] step_period,
    input  logic                    frame_start,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    q_valid,
    output logic                    dir,
    output logic                    beat
);

    localparam logic [ADDR_WIDTH-1:0] POS_LAST = ADDR_WIDTH'(POS_MAX);
    localparam logic [ADDR_WIDTH-1:0] POS_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    fetch_q, fetch_d;
    logic                    q_valid_q, q_valid_d;
    logic                    step;

    // Terminal count of the step counter; a zero period behaves like a period of one.
    function automatic logic [PERIOD_WIDTH-1:0] count_last(input logic [PERIOD_WIDTH-1:0] period);
        return (period == '0) ? '0 : period - PERIOD_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            beat_q    <= 1'b0;
            addr_q    <= '0;
            fetch_q   <= 1'b0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            fetch_q   <= fetch_d;
            q_valid_q <= q_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // >= rather than == so a period shortened below the running count steps at once.
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= count_last(step_period)) begin
                    cnt_d = '0;
                    step  = 1'b1;
                end else begin
                    cnt_d = cnt_q + PERIOD_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        beat_d = 1'b0;

        // Ends are clamped rather than wrapped, so pos can never leave 0..POS_MAX.
        if (step) begin
            if (!dir_q) begin
                if (pos_q >= POS_LAST - POS_ONE) begin
                    pos_d  = POS_LAST;
                    dir_d  = 1'b1;
                    beat_d = 1'b1;
                end else begin
                    pos_d = pos_q + POS_ONE;
                end
            end else begin
                if (pos_q <= POS_ONE) begin
                    pos_d  = '0;
                    dir_d  = 1'b0;
                    beat_d = 1'b1;
                end else begin
                    pos_d = pos_q - POS_ONE;
                end
            end
        end
    end

    // addr captures the pre-step position; q_valid trails by the ROM's one-cycle read.
    always_comb begin
        addr_d    = frame_start ? pos_q : addr_q;
        fetch_d   = frame_start;
        q_valid_d = fetch_q;
    end

    assign addr    = addr_q;
    assign q_valid = q_valid_q;
    assign dir     = dir_q;
    assign beat    = beat_q;

endmodule
